// File: rtl/ifetch_pkg.sv
// Shared types for the instruction-fetch stage.
// IFETCH_FAULT_EN adds a per-entry fault flag (misaligned PC or bus error).
package ifetch_pkg;

    // Entry fields are sized here; ifetch_stage's XLEN must match.
    localparam int unsigned FETCH_XLEN = 32;
    localparam logic [31:0] NOP_INSTR  = 32'h0000_0013;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        DRAIN
    } state_t;

    typedef struct packed {
        logic [31:0]           instr;
        logic [FETCH_XLEN-1:0] pc;
        logic [FETCH_XLEN-1:0] pc_plus4;
`ifdef IFETCH_FAULT_EN
        logic                  fault;
`endif
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Parameterised synchronous FIFO with push/pop/clear and occupancy count.
// Clear has priority over push and pop.
module fetch_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic                     i_clear,
    input  logic [WIDTH-1:0]         i_wdata,
    output logic [WIDTH-1:0]         o_rdata,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [AW:0]      r_count;
    logic             w_push;
    logic             w_pop;

    assign o_empty = (r_count == '0);
    assign o_full  = (r_count == (AW+1)'(DEPTH));
    assign o_count = r_count;
    assign o_rdata = r_mem[r_rptr];
    assign w_pop   = i_pop & ~o_empty;
    assign w_push  = i_push & (~o_full | w_pop);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < DEPTH; i++)
                r_mem[i] <= '0;
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (i_clear) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wptr] <= i_wdata;
                r_wptr        <= r_wptr + 1'b1;
            end
            if (w_pop)
                r_rptr <= r_rptr + 1'b1;
            r_count <= r_count + {{AW{1'b0}}, w_push} - {{AW{1'b0}}, w_pop};
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (reset)
        !(i_push && !i_pop && !i_clear && o_full));

endmodule

// File: rtl/ifetch_stage.sv
// Fetch stage: single-outstanding imem requests, 2-entry buffer towards decode.
// IFETCH_FAULT_EN adds id_fault and NOP substitution for misaligned PC / bus error.
module ifetch_stage #(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned FIFO_DEPTH = 2,
    parameter logic [31:0] NOP_INSTR  = ifetch_pkg::NOP_INSTR
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [XLEN-1:0] pc_curr,
    input  logic            flush,
    output logic            pc_advance,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [31:0]     imem_rsp_data,
    input  logic            imem_rsp_err,
    output logic            id_valid,
    input  logic            id_ready,
    output logic [31:0]     id_instr,
    output logic [XLEN-1:0] id_pc,
    output logic [XLEN-1:0] id_pc_plus4
`ifdef IFETCH_FAULT_EN
    ,
    output logic            id_fault
`endif
);

    import ifetch_pkg::*;

    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

    state_t          r_state;
    state_t          w_next;
    logic [XLEN-1:0] r_req_addr;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] w_req_addr;
    logic            w_misal;
    logic            w_push;
    logic            w_pop;
    logic            w_full;
    logic            w_empty;
    logic            w_space_after;
    logic [CW-1:0]   w_count;
    fetch_entry_t    w_push_entry;
    fetch_entry_t    w_head;

`ifdef IFETCH_FAULT_EN
    assign w_misal    = |pc_curr[1:0];
    assign w_req_addr = pc_curr;
`else
    logic w_unused_err;
    assign w_unused_err = imem_rsp_err;
    assign w_misal      = 1'b0;
    assign w_req_addr   = {pc_curr[XLEN-1:2], 2'b00};
`endif

    assign w_pop          = id_valid & id_ready;
    assign w_space_after  = w_pop | ((32'(w_count) + 32'd1) < 32'(FIFO_DEPTH));
    assign imem_req_addr  = r_req_addr;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= IDLE;
            r_req_addr <= '0;
            r_pc       <= '0;
        end else begin
            r_state <= w_next;
            if (w_next == REQ && r_state != REQ) begin
                r_req_addr <= w_req_addr;
                r_pc       <= pc_curr;
            end
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:  if (!flush && !w_full && !w_misal) w_next = REQ;
            REQ:   if (imem_req_ready)  w_next = flush ? DRAIN : WAIT;
                   else if (flush)      w_next = IDLE;
            WAIT:  if (imem_rsp_valid)  w_next = (!flush && w_space_after && !w_misal) ? REQ : IDLE;
                   else if (flush)      w_next = DRAIN;
            // The pending response always ends the drain; a flush here only clears the buffer.
            DRAIN: if (imem_rsp_valid)  w_next = IDLE;
            default:                    w_next = IDLE;
        endcase
    end

    always_comb begin
        imem_req_valid     = (r_state == REQ);
        pc_advance         = 1'b0;
        w_push             = 1'b0;
        w_push_entry       = '0;
        w_push_entry.instr = NOP_INSTR;
        case (r_state)
`ifdef IFETCH_FAULT_EN
            IDLE: if (!flush && !w_full && w_misal) begin
                w_push                = 1'b1;
                pc_advance            = 1'b1;
                w_push_entry.pc       = pc_curr;
                w_push_entry.pc_plus4 = pc_curr + XLEN'(4);
                w_push_entry.fault    = 1'b1;
            end
`endif
            REQ:  pc_advance = imem_req_ready & ~flush;
            WAIT: if (imem_rsp_valid && !flush) begin
                w_push                = 1'b1;
                w_push_entry.instr    = imem_rsp_data;
                w_push_entry.pc       = r_pc;
                w_push_entry.pc_plus4 = r_pc + XLEN'(4);
`ifdef IFETCH_FAULT_EN
                if (imem_rsp_err) begin
                    w_push_entry.instr = NOP_INSTR;
                    w_push_entry.fault = 1'b1;
                end
`endif
            end
            default: ;
        endcase
    end

    fetch_fifo #(
        .WIDTH ($bits(fetch_entry_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_clear (flush),
        .i_wdata (w_push_entry),
        .o_rdata (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    assign id_valid    = ~w_empty;
    assign id_instr    = w_head.instr;
    assign id_pc       = w_head.pc;
    assign id_pc_plus4 = w_head.pc_plus4;
`ifdef IFETCH_FAULT_EN
    assign id_fault    = w_head.fault;
`endif

endmodule

// File: tb/tb_ifetch_stage.sv
// Directed bench for ifetch_stage with a PC-register model and a simple imem model.
// Fault-path vectors are included when IFETCH_FAULT_EN is defined.
module tb_ifetch_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc_reg;
    logic        flush;
    logic [31:0] flush_target;
    logic        pc_advance;
    logic        imem_req_valid;
    logic        mem_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        imem_rsp_err;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic [31:0] id_pc_plus4;
`ifdef IFETCH_FAULT_EN
    logic        id_fault;
`endif

    logic        mem_go;
    logic        mem_err;
    logic        pend;
    logic [31:0] pend_addr;
    int unsigned req_count;
    int unsigned n_vec = 0;
    int unsigned n_bad = 0;
    int unsigned rc;

    always #5 clk = ~clk;

    ifetch_stage #(
        .XLEN       (32),
        .FIFO_DEPTH (2)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .pc_curr        (pc_reg),
        .flush          (flush),
        .pc_advance     (pc_advance),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (mem_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .imem_rsp_err   (imem_rsp_err),
        .id_valid       (id_valid),
        .id_ready       (id_ready),
        .id_instr       (id_instr),
        .id_pc          (id_pc),
        .id_pc_plus4    (id_pc_plus4)
`ifdef IFETCH_FAULT_EN
        ,
        .id_fault       (id_fault)
`endif
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a == 32'h0) ? 32'h0050_0093 : (a ^ 32'h1000_0000);
    endfunction

    // PC register: redirect wins over increment.
    always @(posedge clk or posedge reset) begin
        if (reset)           pc_reg <= 32'h0;
        else if (flush)      pc_reg <= flush_target;
        else if (pc_advance) pc_reg <= pc_reg + 32'd4;
    end

    // Memory answers in the cycle after acceptance unless held back by mem_go=0.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            imem_rsp_valid <= 1'b0;
            imem_rsp_data  <= 32'h0;
            imem_rsp_err   <= 1'b0;
            pend           <= 1'b0;
            pend_addr      <= 32'h0;
            req_count      <= 0;
        end else begin
            imem_rsp_valid <= 1'b0;
            if (imem_req_valid && mem_ready) begin
                req_count <= req_count + 1;
                if (mem_go) begin
                    imem_rsp_valid <= 1'b1;
                    imem_rsp_data  <= mem_word(imem_req_addr);
                    imem_rsp_err   <= mem_err;
                end else begin
                    pend      <= 1'b1;
                    pend_addr <= imem_req_addr;
                end
            end else if (pend && mem_go) begin
                imem_rsp_valid <= 1'b1;
                imem_rsp_data  <= mem_word(pend_addr);
                imem_rsp_err   <= mem_err;
                pend           <= 1'b0;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h expected %08h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_valid(input string tag);
        int unsigned n = 0;
        while (!id_valid && n < 40) begin
            step();
            n++;
        end
        chk({tag, "_timeout"}, {31'b0, id_valid}, 32'd1);
    endtask

    task automatic wait_req(input string tag);
        int unsigned n = 0;
        while (!imem_req_valid && n < 40) begin
            step();
            n++;
        end
        chk({tag, "_timeout"}, {31'b0, imem_req_valid}, 32'd1);
    endtask

    task automatic wait_rsp(input string tag);
        int unsigned n = 0;
        while (!imem_rsp_valid && n < 40) begin
            step();
            n++;
        end
        chk({tag, "_timeout"}, {31'b0, imem_rsp_valid}, 32'd1);
    endtask

    task automatic wait_pend(input string tag);
        int unsigned n = 0;
        while (!pend && n < 40) begin
            step();
            n++;
        end
        chk({tag, "_timeout"}, {31'b0, pend}, 32'd1);
    endtask

    task automatic do_flush(input logic [31:0] target);
        flush        = 1'b1;
        flush_target = target;
        step();
        flush        = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; flush = 1'b0; flush_target = 32'h0; id_ready = 1'b0;
        mem_ready = 1'b1; mem_go = 1'b1; mem_err = 1'b0;
        step();
        step();
        chk("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
        chk("rst_req_addr",  imem_req_addr,            32'd0);
        chk("rst_pc_adv",    {31'b0, pc_advance},     32'd0);
        chk("rst_id_valid",  {31'b0, id_valid},       32'd0);
        chk("rst_id_instr",  id_instr,                32'd0);
        chk("rst_id_pc",     id_pc,                   32'd0);
        chk("rst_id_pc4",    id_pc_plus4,             32'd0);
`ifdef IFETCH_FAULT_EN
        chk("rst_id_fault",  {31'b0, id_fault},       32'd0);
`endif
        reset = 1'b0;

        // First fetch from PC 0.
        step();
        chk("c1_req_valid", {31'b0, imem_req_valid}, 32'd1);
        chk("c1_req_addr",  imem_req_addr,            32'h0);
        chk("c1_pc_adv",    {31'b0, pc_advance},     32'd1);
        step();
        chk("c2_id_valid",  {31'b0, id_valid},       32'd0);
        step();
        chk("c3_id_valid",  {31'b0, id_valid},       32'd1);
        chk("c3_id_instr",  id_instr,                32'h0050_0093);
        chk("c3_id_pc",     id_pc,                   32'h0);
        chk("c3_id_pc4",    id_pc_plus4,             32'h4);
        chk("c3_req_addr",  imem_req_addr,            32'h4);
`ifdef IFETCH_FAULT_EN
        chk("c3_id_fault",  {31'b0, id_fault},       32'd0);
`endif

        // Decode stalled: buffer fills with two entries and requests stop.
        repeat (6) step();
        chk("stall_req_count", req_count,                32'd2);
        chk("stall_req_valid", {31'b0, imem_req_valid}, 32'd0);
        id_ready = 1'b1;
        chk("pop0_instr", id_instr, 32'h0050_0093);
        step();
        id_ready = 1'b0;
        chk("pop1_instr", id_instr,    32'h1000_0004);
        chk("pop1_pc",    id_pc,       32'h4);
        chk("pop1_pc4",   id_pc_plus4, 32'h8);
        repeat (8) step();
        chk("refill_req_count", req_count,                32'd3);
        chk("refill_req_valid", {31'b0, imem_req_valid}, 32'd0);

        // Flush while a response is outstanding.
        mem_go = 1'b0;
        do_flush(32'h200);
        chk("fl_idle_id_valid", {31'b0, id_valid}, 32'd0);
        wait_pend("fl_wait_pend");
        do_flush(32'h100);
        chk("flw_id_valid",  {31'b0, id_valid},       32'd0);
        chk("flw_req_valid", {31'b0, imem_req_valid}, 32'd0);
        repeat (3) step();
        chk("drain_hold_req", {31'b0, imem_req_valid}, 32'd0);
        mem_go = 1'b1;
        wait_req("flw_req");
        chk("flw_req_addr", imem_req_addr, 32'h100);
        wait_valid("flw_valid");
        chk("flw_id_pc",    id_pc,       32'h100);
        chk("flw_id_instr", id_instr,    32'h1000_0100);
        chk("flw_id_pc4",   id_pc_plus4, 32'h104);

        // Flush in the same cycle as a response.
        wait_rsp("flr_rsp");
        flush = 1'b1;
        flush_target = 32'h300;
        #1;
        chk("flr_pc_adv", {31'b0, pc_advance}, 32'd0);
        step();
        flush = 1'b0;
        chk("flr_id_valid",  {31'b0, id_valid},       32'd0);
        chk("flr_req_valid", {31'b0, imem_req_valid}, 32'd0);
        step();
        chk("flr_req_next",  {31'b0, imem_req_valid}, 32'd1);
        chk("flr_req_addr",  imem_req_addr,            32'h300);

        // Flush on a request handshake suppresses pc_advance; then PC wrap.
        flush = 1'b1;
        flush_target = 32'hFFFF_FFFC;
        #1;
        chk("flq_pc_adv", {31'b0, pc_advance}, 32'd0);
        step();
        flush = 1'b0;
        wait_valid("wrap_valid");
        chk("wrap_id_pc",    id_pc,       32'hFFFF_FFFC);
        chk("wrap_id_pc4",   id_pc_plus4, 32'h0);
        chk("wrap_id_instr", id_instr,    32'hEFFF_FFFC);
        id_ready = 1'b1;
        step();
        id_ready = 1'b0;
        wait_valid("wrap2_valid");
        chk("wrap2_id_pc",    id_pc,       32'h0);
        chk("wrap2_id_pc4",   id_pc_plus4, 32'h4);
        chk("wrap2_id_instr", id_instr,    32'h0050_0093);

`ifdef IFETCH_FAULT_EN
        // Misaligned PC: no request, NOP with fault.
        do_flush(32'h102);
        rc = req_count;
        wait_valid("mis_valid");
        chk("mis_id_instr", id_instr,          32'h0000_0013);
        chk("mis_id_fault", {31'b0, id_fault}, 32'd1);
        chk("mis_id_pc",    id_pc,             32'h102);
        chk("mis_id_pc4",   id_pc_plus4,       32'h106);
        repeat (4) step();
        chk("mis_req_count", req_count,                rc);
        chk("mis_req_valid", {31'b0, imem_req_valid}, 32'd0);

        // Bus error: NOP with fault.
        mem_err = 1'b1;
        do_flush(32'h400);
        wait_valid("err_valid");
        chk("err_id_instr", id_instr,          32'h0000_0013);
        chk("err_id_fault", {31'b0, id_fault}, 32'd1);
        chk("err_id_pc",    id_pc,             32'h400);
        mem_err = 1'b0;
`else
        // Low address bits are dropped and the error flag is ignored.
        mem_err = 1'b1;
        do_flush(32'h102);
        wait_req("al_req");
        chk("al_req_addr", imem_req_addr, 32'h100);
        wait_valid("al_valid");
        chk("al_id_instr", id_instr, 32'h1000_0100);
        mem_err = 1'b0;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
